// File: rtl/round_pipe.sv
// -----------------------------------------------------------------------------
// round_pipe
//
// Two-stage IEEE-style mantissa rounding pipeline. Takes a normalized mantissa
// (hidden bit included) with its guard and sticky bits, applies one of five
// rounding modes, renormalizes on mantissa carry-out and saturates to the
// all-ones exponent on overflow. A valid/ready handshake runs on both sides.
// Each delivered result that was inexact bumps a saturating event counter.
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   in_valid     input transaction valid
//   in_ready     block accepts an input this cycle
//   mant_in      normalized mantissa (MSB = 1 for normals)
//   exp_in       biased exponent
//   guard        first bit below the mantissa LSB
//   sticky       OR of all bits below the guard bit
//   sign         sign of the value being rounded
//   round        rounding mode: 000 RNE, 001 +inf, 010 -inf, 011 zero,
//                100 RNA, 101..111 behave as RNE
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   mant_out     rounded, renormalized mantissa
//   exp_out      exponent after renormalization / saturation
//   sign_out     sign passed through
//   inexact      result differs from the exact value
//   overflow     exponent reached the all-ones encoding
//   cnt_clr      synchronous clear of inexact_cnt (wins over an increment)
//   inexact_cnt  saturating count of delivered inexact results
// -----------------------------------------------------------------------------
module round_pipe #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] mant_in,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic              guard,
   input  logic              sticky,
   input  logic              sign,
   input  logic [2:0]        round,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] mant_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              sign_out,
   output logic              inexact,
   output logic              overflow,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  inexact_cnt
);

   // All-ones exponent, widened by one bit so it compares against the
   // carry-extended exponent sum.
   localparam logic [EXP_W:0]    EXP_LIMIT = {1'b0, {EXP_W{1'b1}}};
   // "1 followed by zeros": value of a renormalized carry and the overflow
   // mantissa.
   localparam logic [MANT_W-1:0] MANT_ONE  = {1'b1, {(MANT_W-1){1'b0}}};

   localparam logic [2:0] MODE_RNE  = 3'b000;
   localparam logic [2:0] MODE_RPI  = 3'b001;
   localparam logic [2:0] MODE_RMI  = 3'b010;
   localparam logic [2:0] MODE_RTZ  = 3'b011;
   localparam logic [2:0] MODE_RNA  = 3'b100;

   // --------------------------------------------------------------------------
   // Rounding helpers
   // --------------------------------------------------------------------------

   // Increment decision for the selected mode. Unused encodings fall back to
   // round-to-nearest-even.
   function automatic logic round_inc(input logic [2:0] mode,
                                      input logic       g,
                                      input logic       s,
                                      input logic       sgn,
                                      input logic       lsb);
      logic inc;
      case (mode)
         MODE_RPI: inc = (g | s) & ~sgn;
         MODE_RMI: inc = (g | s) & sgn;
         MODE_RTZ: inc = 1'b0;
         MODE_RNA: inc = g;
         MODE_RNE: inc = g & (s | lsb);
         default:  inc = g & (s | lsb);
      endcase
      return inc;
   endfunction

   // On carry-out the mantissa shifts right by one; since the only way to
   // carry is all-ones + 1, the shifted value is always 1 followed by zeros.
   function automatic logic [MANT_W-1:0] renorm_mant(input logic [MANT_W:0] sum);
      return sum[MANT_W] ? sum[MANT_W:1] : sum[MANT_W-1:0];
   endfunction

   // Exponent after renormalization, kept one bit wider so that an exponent
   // already at all ones plus a carry is still seen as overflow.
   function automatic logic [EXP_W:0] bump_exp(input logic [EXP_W-1:0] e,
                                                input logic             carry);
      return {1'b0, e} + {{EXP_W{1'b0}}, carry};
   endfunction

   function automatic logic exp_saturates(input logic [EXP_W:0] e_wide);
      return e_wide >= EXP_LIMIT;
   endfunction

   // --------------------------------------------------------------------------
   // Handshake: a stage advances when it is empty or its successor advances.
   // --------------------------------------------------------------------------
   logic vld_p1;
   logic adv1;
   logic adv2;

   assign adv2     = ~out_valid | out_ready;
   assign adv1     = ~vld_p1 | adv2;
   assign in_ready = adv1;

   // --------------------------------------------------------------------------
   // Stage 0 -> 1: increment decision and mantissa sum
   // --------------------------------------------------------------------------
   logic              inc_p0;
   logic [MANT_W:0]   sum_p0;
   logic              inexact_p0;

   assign inc_p0     = round_inc(round, guard, sticky, sign, mant_in[0]);
   assign sum_p0     = {1'b0, mant_in} + {{MANT_W{1'b0}}, inc_p0};
   assign inexact_p0 = guard | sticky;

   logic [MANT_W:0]  sum_p1;
   logic [EXP_W-1:0] exp_p1;
   logic             sign_p1;
   logic             inexact_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1 <= 1'b0;
      end else if (adv1) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         sum_p1     <= sum_p0;
         exp_p1     <= exp_in;
         sign_p1    <= sign;
         inexact_p1 <= inexact_p0;
      end
   end

   // --------------------------------------------------------------------------
   // Stage 1 -> 2: renormalization, exponent saturation, output registers
   // --------------------------------------------------------------------------
   logic              carry_p1;
   logic [EXP_W:0]    exp_wide_p1;
   logic              ovf_p1;
   logic [MANT_W-1:0] mant_fin_p1;
   logic [EXP_W-1:0]  exp_fin_p1;

   assign carry_p1    = sum_p1[MANT_W];
   assign exp_wide_p1 = bump_exp(exp_p1, carry_p1);
   assign ovf_p1      = exp_saturates(exp_wide_p1);
   assign mant_fin_p1 = ovf_p1 ? MANT_ONE : renorm_mant(sum_p1);
   assign exp_fin_p1  = ovf_p1 ? {EXP_W{1'b1}} : exp_wide_p1[EXP_W-1:0];

   // Result registers clear on reset so nothing stale is visible afterwards;
   // they only load when a valid transaction moves in, which keeps them
   // stable while the downstream stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         mant_out  <= '0;
         exp_out   <= '0;
         sign_out  <= 1'b0;
         inexact   <= 1'b0;
         overflow  <= 1'b0;
      end else if (adv2) begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            mant_out <= mant_fin_p1;
            exp_out  <= exp_fin_p1;
            sign_out <= sign_p1;
            inexact  <= inexact_p1;
            overflow <= ovf_p1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Inexact event counter: counts results actually handed downstream.
   // --------------------------------------------------------------------------
   logic deliver_inexact;

   assign deliver_inexact = out_valid & out_ready & inexact;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inexact_cnt <= '0;
      end else if (cnt_clr) begin
         inexact_cnt <= '0;
      end else if (deliver_inexact && (inexact_cnt != {CNT_W{1'b1}})) begin
         inexact_cnt <= inexact_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_round_pipe.sv
// -----------------------------------------------------------------------------
// tb_round_pipe
//
// Drives round_pipe with directed vectors, a backpressure burst, a mid-flight
// reset and a long randomized run. A queue of accepted transactions holds the
// results computed from the rounding rules with plain integer arithmetic; the
// DUT outputs are compared against it every cycle.
// -----------------------------------------------------------------------------
module tb_round_pipe;

   localparam int MW = 24;
   localparam int EW = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] mant_in;
   logic [EW-1:0] exp_in;
   logic          guard;
   logic          sticky;
   logic          sign;
   logic [2:0]    round;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] mant_out;
   logic [EW-1:0] exp_out;
   logic          sign_out;
   logic          inexact;
   logic          overflow;
   logic          cnt_clr;
   logic [CW-1:0] inexact_cnt;

   round_pipe #(.MANT_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .mant_in(mant_in), .exp_in(exp_in),
      .guard(guard), .sticky(sticky), .sign(sign), .round(round),
      .out_valid(out_valid), .out_ready(out_ready),
      .mant_out(mant_out), .exp_out(exp_out), .sign_out(sign_out),
      .inexact(inexact), .overflow(overflow),
      .cnt_clr(cnt_clr), .inexact_cnt(inexact_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [MW-1:0] m;
      logic [EW-1:0] e;
      logic          g;
      logic          s;
      logic          sg;
      logic [2:0]    rd;
   } stim_t;

   typedef struct packed {
      logic [MW-1:0] mant;
      logic [EW-1:0] exp;
      logic          sign;
      logic          inx;
      logic          ovf;
   } res_t;

   typedef struct {
      res_t r;
      int   cap;
   } ent_t;

   ent_t q[$];
   int   edge_n = 0;
   int   cnt_m  = 0;
   int   total  = 0;
   int   bad    = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Expected result straight from the rounding rules.
   function automatic res_t model(input stim_t st);
      res_t    r;
      int      inc;
      longint  sum;
      int      ex;
      case (st.rd)
         3'd1:    inc = ((st.g || st.s) && !st.sg) ? 1 : 0;
         3'd2:    inc = ((st.g || st.s) && st.sg) ? 1 : 0;
         3'd3:    inc = 0;
         3'd4:    inc = st.g ? 1 : 0;
         default: inc = (st.g && (st.s || st.m[0])) ? 1 : 0;
      endcase
      sum   = longint'(st.m) + inc;
      ex    = int'(st.e);
      r.ovf = 1'b0;
      if (sum >= (64'd1 << MW)) begin
         sum = sum / 2;
         ex  = ex + 1;
      end
      if (ex >= (1 << EW) - 1) begin
         ex    = (1 << EW) - 1;
         sum   = 64'd1 << (MW - 1);
         r.ovf = 1'b1;
      end
      r.mant = MW'(sum);
      r.exp  = EW'(ex);
      r.sign = st.sg;
      r.inx  = st.g | st.s;
      return r;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.m = {1'b1, 23'($urandom)};
      if ($urandom_range(0, 3) == 0) s.m = 24'hFFFFFF;
      if ($urandom_range(0, 7) == 0) s.e = 8'(250 + $urandom_range(0, 5));
      else                          s.e = 8'($urandom);
      s.g  = 1'($urandom_range(0, 1));
      s.s  = 1'($urandom_range(0, 1));
      s.sg = 1'($urandom_range(0, 1));
      s.rd = 3'($urandom);
      return s;
   endfunction

   // One clock cycle: drive at the falling edge, check 1 ns later, then
   // advance the model at the rising edge using the observed handshakes.
   task automatic step(input logic v, input stim_t st, input logic ordy,
                       input logic clr, output logic acc);
      logic fire;
      logic exp_vld;
      ent_t e;
      res_t got;
      @(negedge clk);
      in_valid  = v;
      mant_in   = st.m;
      exp_in    = st.e;
      guard     = st.g;
      sticky    = st.s;
      sign      = st.sg;
      round     = st.rd;
      out_ready = ordy;
      cnt_clr   = clr;
      #1;
      exp_vld = (q.size() > 0) && (edge_n - q[0].cap >= 1);
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      check("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
      if (exp_vld && out_valid) begin
         got = {mant_out, exp_out, sign_out, inexact, overflow};
         check("result", 64'(got), 64'(q[0].r));
      end
      check("inexact_cnt", 64'(inexact_cnt), 64'(cnt_m));
      acc  = v & in_ready;
      fire = out_valid & ordy;
      @(posedge clk);
      edge_n++;
      if (clr) begin
         cnt_m = 0;
      end else if (fire && q.size() > 0 && q[0].r.inx && cnt_m < (1 << CW) - 1) begin
         cnt_m = cnt_m + 1;
      end
      if (fire && q.size() > 0) void'(q.pop_front());
      if (acc) begin
         e.r   = model(st);
         e.cap = edge_n;
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_cnt", 64'(inexact_cnt), 64'd0);
      check("rst_data", 64'({mant_out, exp_out, sign_out, inexact, overflow}), 64'd0);
      q.delete();
      cnt_m = 0;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      edge_n++;
   endtask

   stim_t dvec[9];
   stim_t bvec[4];
   stim_t idle;
   logic  acc;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      idle      = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      mant_in   = '0;
      exp_in    = '0;
      guard     = 1'b0;
      sticky    = 1'b0;
      sign      = 1'b0;
      round     = 3'd0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;

      // Power-on reset, checked before any clock edge reaches the DUT.
      #2 rst = 1'b0;
      #1;
      check("por_out_valid", 64'(out_valid), 64'd0);
      check("por_in_ready", 64'(in_ready), 64'd1);
      check("por_cnt", 64'(inexact_cnt), 64'd0);
      check("por_data", 64'({mant_out, exp_out, sign_out, inexact, overflow}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed vectors with hand-computed results.
      dvec[0] = '{m:24'hFFFFFF, e:8'd100, g:1'b1, s:1'b0, sg:1'b0, rd:3'd0};
      dvec[1] = '{m:24'h800000, e:8'd100, g:1'b1, s:1'b0, sg:1'b0, rd:3'd0};
      dvec[2] = '{m:24'h800000, e:8'd100, g:1'b1, s:1'b0, sg:1'b0, rd:3'd4};
      dvec[3] = '{m:24'hA00000, e:8'd50,  g:1'b0, s:1'b1, sg:1'b0, rd:3'd1};
      dvec[4] = '{m:24'hA00000, e:8'd50,  g:1'b0, s:1'b1, sg:1'b1, rd:3'd1};
      dvec[5] = '{m:24'hA00000, e:8'd50,  g:1'b0, s:1'b1, sg:1'b1, rd:3'd2};
      dvec[6] = '{m:24'hA00000, e:8'd50,  g:1'b0, s:1'b1, sg:1'b0, rd:3'd3};
      dvec[7] = '{m:24'hA00000, e:8'd50,  g:1'b0, s:1'b1, sg:1'b0, rd:3'd7};
      dvec[8] = '{m:24'hFFFFFF, e:8'd254, g:1'b1, s:1'b1, sg:1'b0, rd:3'd0};

      check("pin_rne_odd",  64'(model(dvec[0])), 64'({24'h800000, 8'd101, 1'b0, 1'b1, 1'b0}));
      check("pin_rne_even", 64'(model(dvec[1])), 64'({24'h800000, 8'd100, 1'b0, 1'b1, 1'b0}));
      check("pin_rna_tie",  64'(model(dvec[2])), 64'({24'h800001, 8'd100, 1'b0, 1'b1, 1'b0}));
      check("pin_rpi_pos",  64'(model(dvec[3])), 64'({24'hA00001, 8'd50, 1'b0, 1'b1, 1'b0}));
      check("pin_rpi_neg",  64'(model(dvec[4])), 64'({24'hA00000, 8'd50, 1'b1, 1'b1, 1'b0}));
      check("pin_rmi_neg",  64'(model(dvec[5])), 64'({24'hA00001, 8'd50, 1'b1, 1'b1, 1'b0}));
      check("pin_rtz",      64'(model(dvec[6])), 64'({24'hA00000, 8'd50, 1'b0, 1'b1, 1'b0}));
      check("pin_mode7",    64'(model(dvec[7])), 64'({24'hA00000, 8'd50, 1'b0, 1'b1, 1'b0}));
      check("pin_overflow", 64'(model(dvec[8])), 64'({24'h800000, 8'd255, 1'b0, 1'b1, 1'b1}));

      for (int i = 0; i < 9; i++) step(1'b1, dvec[i], 1'b1, 1'b0, acc);
      for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, acc);

      // Backpressure: four back-to-back inputs, downstream stalled 3 cycles.
      bvec[0] = '{m:24'hC00001, e:8'd10, g:1'b1, s:1'b0, sg:1'b0, rd:3'd0};
      bvec[1] = '{m:24'hC00002, e:8'd11, g:1'b0, s:1'b0, sg:1'b1, rd:3'd1};
      bvec[2] = '{m:24'hFFFFFF, e:8'd12, g:1'b0, s:1'b1, sg:1'b0, rd:3'd1};
      bvec[3] = '{m:24'h912345, e:8'd13, g:1'b1, s:1'b1, sg:1'b1, rd:3'd3};
      begin
         int idx;
         idx = 0;
         for (int c = 0; c < 20; c++) begin
            if (idx < 4) step(1'b1, bvec[idx], (c >= 3), 1'b0, acc);
            else         step(1'b0, idle, 1'b1, 1'b0, acc);
            if (acc) idx++;
         end
         check("bp_all_accepted", 64'(idx), 64'd4);
         check("bp_drained", 64'(q.size()), 64'd0);
      end

      // Mid-flight reset with two transactions in the pipe.
      step(1'b1, dvec[0], 1'b0, 1'b0, acc);
      step(1'b1, dvec[3], 1'b0, 1'b0, acc);
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, acc);

      // Randomized traffic with random backpressure and occasional clears.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 9) < 7), rand_stim(),
              1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) == 0), acc);
      end
      for (int i = 0; i < 6; i++) step(1'b0, idle, 1'b1, 1'b0, acc);
      check("final_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/round_pipe.md
ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 SHALL have parameter MANT_W, default 24, mantissa width including hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, biased exponent width.
REQ-003 SHALL have parameter CNT_W, default 16, inexact-event counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input transaction valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port mant_in  input  MANT_W  normalized mantissa, MSB=1 for normals.
REQ-009 SHALL have port exp_in  input  EXP_W  biased exponent.
REQ-010 SHALL have port guard, sticky, sign  input  1 each  guard bit, OR of lower bits, sign.
REQ-011 SHALL have port round  input  3  rounding mode.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port mant_out  output  MANT_W  rounded, renormalized mantissa.
REQ-015 SHALL have ports exp_out  output  EXP_W, and sign_out  output  1 (passed through).
REQ-016 SHALL have ports inexact, overflow  output  1 each  per-result flags.
REQ-017 SHALL have port cnt_clr  input  1  synchronous clear of inexact_cnt.
REQ-018 SHALL have port inexact_cnt  output  CNT_W  count of delivered inexact results.

Function
REQ-019 SHALL decode round: 000 nearest-even, 001 toward +inf, 010 toward -inf, 011 toward zero, 100 nearest-away; 101-111 treated as 000.
REQ-020 SHALL set increment: RNE = guard & (sticky | mant_in[0]); +inf = (guard|sticky) & ~sign; -inf = (guard|sticky) & sign; zero = 0; RNA = guard.
REQ-021 SHALL set inexact = guard | sticky, independent of mode.
REQ-022 SHALL form sum = mant_in + increment in MANT_W+1 bits; on carry-out, mant_out = sum[MANT_W:1] (= 1 followed by zeros) and exp_out = exp_in + 1, else mant_out = sum[MANT_W-1:0], exp_out = exp_in.
REQ-023 SHALL set overflow = 1 when exp_out (EXP_W+1-bit sum) >= 2^EXP_W - 1; exp_out then SHALL be all ones, mant_out SHALL be 1 followed by zeros.
REQ-024 SHALL be a 2-stage pipeline: stage 1 registers increment decision and sum; stage 2 registers renormalized outputs; latency 2 cycles from accepted input to out_valid with no stall.
REQ-025 SHALL advance stage 2 when adv2 = ~out_valid | out_ready; stage 1 when adv1 = ~s1_valid | adv2; in_ready = adv1.
REQ-026 SHALL accept input only when in_valid & in_ready; throughput one result per cycle with out_ready held 1.
REQ-027 SHALL hold mant_out, exp_out, sign_out, inexact, overflow stable while out_valid & ~out_ready.
REQ-028 SHALL never drop or duplicate a transaction under any out_ready pattern.
REQ-029 SHALL increment inexact_cnt by 1 on each cycle out_valid & out_ready & inexact; saturate at all ones.
REQ-030 SHALL give cnt_clr priority over a simultaneous increment (result 0).

Reset
REQ-031 SHALL on rst low, asynchronously clear s1_valid, out_valid, inexact_cnt, and all data/flag outputs to 0.
REQ-032 SHALL drive in_ready = 1 during and after reset; in-flight transactions are discarded.

Verification
REQ-033 RNE tie, odd LSB: mant_in=FFFFFF, exp_in=100, g=1, s=0, round=000 -> 2 cycles later mant_out=800000, exp_out=101, inexact=1, overflow=0.
REQ-034 RNE tie, even LSB: mant_in=800000, g=1, s=0 -> mant_out=800000, inexact=1; same with round=100 -> 800001.
REQ-035 Directed modes, mant_in=A00000, g=0, s=1: round=001 sign=0 -> A00001; sign=1 -> A00000; round=010 sign=1 -> A00001; round=011 -> A00000; round=111 -> A00000.
REQ-036 Overflow: mant_in=FFFFFF, exp_in=254, g=1, s=1, round=000 -> exp_out=255, overflow=1, mant_out=800000.
REQ-037 Backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles then 1 -> in_ready drops after 2 accepted, all 4 outputs in order, outputs stable while stalled, inexact_cnt = number of inexact ones.
REQ-038 Reset mid-flight with 2 transactions in pipe, rst low one cycle -> out_valid=0, inexact_cnt=0 immediately; no stale output after release.
